ex2_mem_stage: RTL and testbench

Second execute stage of the dual-issue pipeline; sits directly downstream of EX1 and upstream of writeback. Holds one issue pair and finishes the multiply from EX1's four 16×16 partial products. Waits for the dcache read response and aligns and extends load data. Presents writeback results and the ex1_ex2 forwarding bus that EX1 consumes.

---
 rtl/ex2_mem_stage.sv | 176 +++++++++++++++++
 tb/tb_ex2_mem_stage.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex2_mem_stage.sv
// Second execute stage: finishes the multiply, waits for and extends dcache load data, drives WB and EX1 forwarding.
// Optional macro EX2_LOAD_FWD_EN: bypass load data onto fwd_data0 in the dcache response cycle.
module ex2_mem_stage #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc0,
  input  logic [4:0]        in_rd0,
  input  logic [4:0]        in_rd1,
  input  logic              in_we0,
  input  logic              in_we1,
  input  logic [DATA_W-1:0] in_res0,
  input  logic [DATA_W-1:0] in_res1,
  input  logic              in_is_mul,
  input  logic              in_mul_hi,
  input  logic [DATA_W-1:0] in_pp_hh,
  input  logic [DATA_W-1:0] in_pp_hl,
  input  logic [DATA_W-1:0] in_pp_lh,
  input  logic [DATA_W-1:0] in_pp_ll,
  input  logic [DATA_W-1:0] in_pp_comp,
  input  logic              in_is_load,
  input  logic [1:0]        in_ld_type,
  input  logic              in_ld_sign,
  input  logic [1:0]        in_addr_lo,
  input  logic              in_excp,
  input  logic              excp_flush,
  input  logic              dcache_rready,
  input  logic [DATA_W-1:0] dcache_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wb_pc0,
  output logic [4:0]        wb_rd0,
  output logic [4:0]        wb_rd1,
  output logic              wb_we0,
  output logic              wb_we1,
  output logic [DATA_W-1:0] wb_data0,
  output logic [DATA_W-1:0] wb_data1,
  output logic              wb_excp,
  output logic [4:0]        fwd_rd0,
  output logic [4:0]        fwd_rd1,
  output logic [DATA_W-1:0] fwd_data0,
  output logic [DATA_W-1:0] fwd_data1,
  output logic              fwd_valid0,
  output logic              fwd_valid1
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned HALF_W = DATA_W / 2;

  typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

  state_t            state, state_nxt;
  logic              drop, drop_nxt;
  logic              accept;
  logic              load_take;
  logic [PROD_W-1:0] product;
  logic [DATA_W-1:0] mul_res;
  logic [DATA_W-1:0] ld_ext;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [1:0]        ld_type_q;
  logic              ld_sign_q;
  logic [1:0]        addr_lo_q;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready & ~excp_flush;
  // A response seen while drop is set belongs to a flushed load.
  assign load_take = (state == MEM) & dcache_rready & ~drop;

  assign product = (PROD_W'(in_pp_hh)   << DATA_W)
                 + (PROD_W'(in_pp_hl)   << HALF_W)
                 + (PROD_W'(in_pp_lh)   << HALF_W)
                 +  PROD_W'(in_pp_ll)
                 + (PROD_W'(in_pp_comp) << DATA_W);
  assign mul_res = in_mul_hi ? product[PROD_W-1:DATA_W] : product[DATA_W-1:0];

  // Load alignment and extension from the held load attributes.
  always_comb begin
    ld_byte = dcache_rdata[{addr_lo_q, 3'b000} +: 8];
    ld_half = addr_lo_q[1] ? dcache_rdata[31:16] : dcache_rdata[15:0];
    ld_ext  = dcache_rdata;
    case (ld_type_q)
      2'd0:    ld_ext = ld_sign_q ? {{(DATA_W-8){ld_byte[7]}}, ld_byte}
                                  : {{(DATA_W-8){1'b0}}, ld_byte};
      2'd1:    ld_ext = ld_sign_q ? {{(DATA_W-16){ld_half[15]}}, ld_half}
                                  : {{(DATA_W-16){1'b0}}, ld_half};
      default: ld_ext = dcache_rdata;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    if (dcache_rready) drop_nxt = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = (in_is_load & ~in_excp) ? MEM : DONE;
      MEM:  if (load_take) state_nxt = DONE;
      DONE: begin
        if (accept)         state_nxt = (in_is_load & ~in_excp) ? MEM : DONE;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Flush wins; an unconsumed outstanding response must be discarded later.
    if (excp_flush) begin
      state_nxt = IDLE;
      if ((state == MEM) && !load_take) drop_nxt = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      wb_pc0    <= '0;
      wb_rd0    <= '0;
      wb_rd1    <= '0;
      wb_we0    <= 1'b0;
      wb_we1    <= 1'b0;
      wb_data0  <= '0;
      wb_data1  <= '0;
      wb_excp   <= 1'b0;
      ld_type_q <= '0;
      ld_sign_q <= 1'b0;
      addr_lo_q <= '0;
    end else begin
      out_valid <= (state_nxt == DONE);
      if (accept) begin
        wb_pc0    <= in_pc0;
        wb_rd0    <= in_rd0;
        wb_rd1    <= in_rd1;
        wb_we0    <= in_we0 & ~in_excp;
        wb_we1    <= in_we1 & ~in_excp;
        wb_data0  <= in_is_mul ? mul_res : in_res0;
        wb_data1  <= in_res1;
        wb_excp   <= in_excp;
        ld_type_q <= in_ld_type;
        ld_sign_q <= in_ld_sign;
        addr_lo_q <= in_addr_lo;
      end else if (load_take) begin
        wb_data0 <= ld_ext;
      end
    end
  end

  assign fwd_rd0   = wb_rd0;
  assign fwd_rd1   = wb_rd1;
  assign fwd_data1 = wb_data1;

  // Lane 1 is final as soon as the pair is held; lane 0 waits for the load.
  always_comb begin
    fwd_valid0 = (state == DONE) & wb_we0;
    fwd_data0  = wb_data0;
    fwd_valid1 = ((state == DONE) | (state == MEM)) & wb_we1;
`ifdef EX2_LOAD_FWD_EN
    if (load_take) begin
      fwd_valid0 = wb_we0;
      fwd_data0  = ld_ext;
    end
`else
`endif
  end

endmodule

// File: tb/tb_ex2_mem_stage.sv
// Self-checking bench for ex2_mem_stage: directed vector table, hand sequences, and a randomized run against a reference model.
module tb_ex2_mem_stage;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        in_valid, in_ready;
  logic [31:0] in_pc0;
  logic [4:0]  in_rd0, in_rd1;
  logic        in_we0, in_we1;
  logic [31:0] in_res0, in_res1;
  logic        in_is_mul, in_mul_hi;
  logic [31:0] in_pp_hh, in_pp_hl, in_pp_lh, in_pp_ll, in_pp_comp;
  logic        in_is_load;
  logic [1:0]  in_ld_type;
  logic        in_ld_sign;
  logic [1:0]  in_addr_lo;
  logic        in_excp, excp_flush, dcache_rready;
  logic [31:0] dcache_rdata;
  logic        out_valid, out_ready;
  logic [31:0] wb_pc0;
  logic [4:0]  wb_rd0, wb_rd1;
  logic        wb_we0, wb_we1;
  logic [31:0] wb_data0, wb_data1;
  logic        wb_excp;
  logic [4:0]  fwd_rd0, fwd_rd1;
  logic [31:0] fwd_data0, fwd_data1;
  logic        fwd_valid0, fwd_valid1;

  int tests = 0;
  int fails = 0;

  always #5 aclk = ~aclk;

  ex2_mem_stage #(.DATA_W(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc0(in_pc0),
    .in_rd0(in_rd0), .in_rd1(in_rd1), .in_we0(in_we0), .in_we1(in_we1),
    .in_res0(in_res0), .in_res1(in_res1), .in_is_mul(in_is_mul), .in_mul_hi(in_mul_hi),
    .in_pp_hh(in_pp_hh), .in_pp_hl(in_pp_hl), .in_pp_lh(in_pp_lh), .in_pp_ll(in_pp_ll),
    .in_pp_comp(in_pp_comp), .in_is_load(in_is_load), .in_ld_type(in_ld_type),
    .in_ld_sign(in_ld_sign), .in_addr_lo(in_addr_lo), .in_excp(in_excp),
    .excp_flush(excp_flush), .dcache_rready(dcache_rready), .dcache_rdata(dcache_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .wb_pc0(wb_pc0),
    .wb_rd0(wb_rd0), .wb_rd1(wb_rd1), .wb_we0(wb_we0), .wb_we1(wb_we1),
    .wb_data0(wb_data0), .wb_data1(wb_data1), .wb_excp(wb_excp),
    .fwd_rd0(fwd_rd0), .fwd_rd1(fwd_rd1), .fwd_data0(fwd_data0), .fwd_data1(fwd_data1),
    .fwd_valid0(fwd_valid0), .fwd_valid1(fwd_valid1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; in_pc0 = 0; in_rd0 = 0; in_rd1 = 0; in_we0 = 0; in_we1 = 0;
    in_res0 = 0; in_res1 = 0; in_is_mul = 0; in_mul_hi = 0;
    in_pp_hh = 0; in_pp_hl = 0; in_pp_lh = 0; in_pp_ll = 0; in_pp_comp = 0;
    in_is_load = 0; in_ld_type = 0; in_ld_sign = 0; in_addr_lo = 0; in_excp = 0;
    excp_flush = 0; dcache_rready = 0; dcache_rdata = 0; out_ready = 1;
  endtask

  // Reference arithmetic: full 64-bit product sum, then pick a half.
  function automatic logic [31:0] mul_ref(input logic [31:0] hh, hl, lh, ll, comp, input logic hi);
    longint unsigned p;
    p = longint'(hh) * 64'h1_0000_0000 + longint'(hl) * 65536 + longint'(lh) * 65536
      + longint'(ll) + longint'(comp) * 64'h1_0000_0000;
    return hi ? p[63:32] : p[31:0];
  endfunction

  function automatic logic [31:0] ext_ref(input logic [31:0] w, input logic [1:0] t,
                                          input logic s, input logic [1:0] a);
    logic [31:0] v;
    if (t == 2'd0) begin
      v = (w >> (8 * a)) & 32'hFF;
      if (s && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (t == 2'd1) begin
      v = (w >> (16 * (a / 2))) & 32'hFFFF;
      if (s && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  typedef struct {
    logic        is_mul, mul_hi, is_load, excp, we0, we1;
    logic [31:0] res0, res1, hh, hl, lh, ll, comp;
    logic [31:0] exp_d0;
    logic        exp_we0, exp_excp;
  } vec_t;

  vec_t vecs[6];

  // Reference model state for the randomized phase.
  bit          m_full, m_wait;
  int          m_dead;
  logic [31:0] e_pc, e_d0, e_d1;
  logic [4:0]  e_rd0, e_rd1;
  logic        e_we0, e_we1, e_excp, e_sign;
  logic [1:0]  e_type, e_addr;

  initial begin
    clear_inputs();
    aresetn = 0;
    repeat (3) cycle();
    aresetn = 1;
    #1;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst wb_we0", 32'(wb_we0), 0);
    chk("rst wb_excp", 32'(wb_excp), 0);
    chk("rst fwd_valid0", 32'(fwd_valid0), 0);
    chk("rst fwd_valid1", 32'(fwd_valid1), 0);
    chk("rst wb_data0", wb_data0, 0);
    chk("rst wb_pc0", wb_pc0, 0);
    chk("rst fwd_data1", fwd_data1, 0);
    chk("rst fwd_rd0", 32'(fwd_rd0), 0);

    // is_mul mul_hi is_load excp we0 we1 res0 res1 hh hl lh ll comp | d0 we0 excp
    vecs[0] = '{0, 0, 0, 0, 1, 1, 32'h5, 32'hA5, 0, 0, 0, 0, 0, 32'h5, 1, 0};
    vecs[1] = '{1, 0, 0, 0, 1, 0, 32'h0, 32'h1, 0, 32'h1, 32'h1, 32'h10, 0, 32'h0002_0010, 1, 0};
    vecs[2] = '{1, 1, 0, 0, 1, 1, 32'h0, 32'h2, 32'h1, 32'h8000_0000, 32'h8000_0000, 0,
                32'hFFFF_FFFF, 32'h0001_0000, 1, 0};
    vecs[3] = '{1, 0, 0, 0, 1, 0, 32'h0, 32'h3, 0, 32'h1, 0, 32'hFFFF_FFFF, 0, 32'h0000_FFFF, 1, 0};
    vecs[4] = '{0, 0, 1, 1, 1, 1, 32'h77, 32'h4, 0, 0, 0, 0, 0, 32'h77, 0, 1};
    vecs[5] = '{0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 32'h5, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0};

    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      in_valid = 1; in_pc0 = 32'h1000 + 32'(i) * 4; in_rd0 = 5'(i + 1); in_rd1 = 5'(i + 10);
      in_is_mul = vecs[i].is_mul; in_mul_hi = vecs[i].mul_hi; in_is_load = vecs[i].is_load;
      in_excp = vecs[i].excp; in_we0 = vecs[i].we0; in_we1 = vecs[i].we1;
      in_res0 = vecs[i].res0; in_res1 = vecs[i].res1; in_pp_hh = vecs[i].hh;
      in_pp_hl = vecs[i].hl; in_pp_lh = vecs[i].lh; in_pp_ll = vecs[i].ll; in_pp_comp = vecs[i].comp;
      cycle();
      in_valid = 0;
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 1);
      chk($sformatf("vec%0d wb_data0", i), wb_data0, vecs[i].exp_d0);
      chk($sformatf("vec%0d wb_data1", i), wb_data1, vecs[i].res1);
      chk($sformatf("vec%0d wb_we0", i), 32'(wb_we0), 32'(vecs[i].exp_we0));
      chk($sformatf("vec%0d wb_we1", i), 32'(wb_we1), 32'(vecs[i].we1 & ~vecs[i].excp));
      chk($sformatf("vec%0d wb_excp", i), 32'(wb_excp), 32'(vecs[i].exp_excp));
      chk($sformatf("vec%0d wb_pc0", i), wb_pc0, 32'h1000 + 32'(i) * 4);
      chk($sformatf("vec%0d fwd_rd0", i), 32'(fwd_rd0), 32'(i + 1));
      chk($sformatf("vec%0d fwd_valid0", i), 32'(fwd_valid0), 32'(vecs[i].exp_we0));
      cycle();
      chk($sformatf("vec%0d retired", i), 32'(out_valid), 0);
    end

    // Sign-extended byte load, response after three idle cycles.
    clear_inputs();
    in_valid = 1; in_is_load = 1; in_ld_type = 0; in_ld_sign = 1; in_addr_lo = 2;
    in_we0 = 1; in_we1 = 1; in_rd0 = 7; in_res1 = 32'h99;
    cycle();
    in_valid = 0;
    for (int c = 0; c < 3; c++) begin
      chk("ld wait out_valid", 32'(out_valid), 0);
      chk("ld wait fwd_valid0", 32'(fwd_valid0), 0);
      chk("ld wait fwd_valid1", 32'(fwd_valid1), 1);
      chk("ld wait in_ready", 32'(in_ready), 0);
      cycle();
    end
    dcache_rready = 1; dcache_rdata = 32'h0080_FF00;
    #1;
`ifdef EX2_LOAD_FWD_EN
    chk("ld bypass fwd_valid0", 32'(fwd_valid0), 1);
    chk("ld bypass fwd_data0", fwd_data0, 32'hFFFF_FF80);
`else
    chk("ld resp fwd_valid0", 32'(fwd_valid0), 0);
`endif
    cycle();
    dcache_rready = 0;
    chk("ld out_valid", 32'(out_valid), 1);
    chk("ld wb_data0", wb_data0, 32'hFFFF_FF80);
    chk("ld fwd_valid0", 32'(fwd_valid0), 1);
    chk("ld fwd_data0", fwd_data0, 32'hFFFF_FF80);
    cycle();

    // Flush in MEM: the stale response must not reach the next load.
    clear_inputs();
    in_valid = 1; in_is_load = 1; in_ld_type = 2; in_we0 = 1;
    cycle();
    in_valid = 0; excp_flush = 1;
    cycle();
    excp_flush = 0;
    chk("flush out_valid", 32'(out_valid), 0);
    chk("flush in_ready", 32'(in_ready), 1);
    in_valid = 1;
    cycle();
    in_valid = 0; dcache_rready = 1; dcache_rdata = 32'hAAAA_AAAA;
    #1;
    chk("stale fwd_valid0", 32'(fwd_valid0), 0);
    cycle();
    chk("stale dropped", 32'(out_valid), 0);
    dcache_rdata = 32'h1234_5678;
    cycle();
    dcache_rready = 0;
    chk("post-flush out_valid", 32'(out_valid), 1);
    chk("post-flush wb_data0", wb_data0, 32'h1234_5678);
    cycle();

    // Backpressure, then retire and accept in the same cycle.
    clear_inputs();
    in_valid = 1; in_res0 = 32'h11; in_we0 = 1; out_ready = 0;
    cycle();
    in_res0 = 32'h22;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp in_ready", 32'(in_ready), 0);
      chk("bp out_valid", 32'(out_valid), 1);
      chk("bp wb_data0", wb_data0, 32'h11);
      cycle();
    end
    out_ready = 1;
    #1;
    chk("b2b in_ready", 32'(in_ready), 1);
    cycle();
    in_valid = 0;
    chk("b2b out_valid", 32'(out_valid), 1);
    chk("b2b wb_data0", wb_data0, 32'h22);
    cycle();
    chk("b2b drained", 32'(out_valid), 0);

    // Randomized run against the reference model.
    clear_inputs();
    m_full = 0; m_wait = 0; m_dead = 0;
    for (int n = 0; n < 3000; n++) begin
      bit exp_ready, acc, was_done, resp, exp_fv0, exp_fv1;
      logic [31:0] exp_fd0;
      int op;
      op = $urandom_range(0, 2);
      in_valid = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      excp_flush = (m_dead == 0) && ($urandom_range(0, 19) == 0);
      dcache_rready = ($urandom_range(0, 2) == 0);
      dcache_rdata = $urandom;
      in_pc0 = $urandom; in_rd0 = 5'($urandom); in_rd1 = 5'($urandom);
      in_we0 = 1'($urandom); in_we1 = 1'($urandom);
      in_res0 = $urandom; in_res1 = $urandom;
      in_is_mul = (op == 1); in_is_load = (op == 2); in_mul_hi = 1'($urandom);
      in_pp_hh = $urandom; in_pp_hl = $urandom; in_pp_lh = $urandom;
      in_pp_ll = $urandom; in_pp_comp = $urandom;
      in_ld_type = 2'($urandom_range(0, 2)); in_ld_sign = 1'($urandom);
      in_addr_lo = 2'($urandom); in_excp = ($urandom_range(0, 7) == 0);
      #1;
      exp_ready = !m_full || (!m_wait && out_ready);
      resp = dcache_rready && m_dead == 0 && m_full && m_wait;
      exp_fv0 = m_full && !m_wait && e_we0;
      exp_fd0 = e_d0;
`ifdef EX2_LOAD_FWD_EN
      if (resp && e_we0) begin
        exp_fv0 = 1;
        exp_fd0 = ext_ref(dcache_rdata, e_type, e_sign, e_addr);
      end
`endif
      exp_fv1 = m_full && e_we1;
      chk("rnd in_ready", 32'(in_ready), 32'(exp_ready));
      chk("rnd out_valid", 32'(out_valid), 32'(m_full && !m_wait));
      chk("rnd fwd_valid0", 32'(fwd_valid0), 32'(exp_fv0));
      chk("rnd fwd_valid1", 32'(fwd_valid1), 32'(exp_fv1));
      if (exp_fv0) chk("rnd fwd_data0", fwd_data0, exp_fd0);
      if (exp_fv1) chk("rnd fwd_data1", fwd_data1, e_d1);
      if (m_full && !m_wait) begin
        chk("rnd wb_pc0", wb_pc0, e_pc);
        chk("rnd wb_data0", wb_data0, e_d0);
        chk("rnd wb_data1", wb_data1, e_d1);
        chk("rnd wb_rd0", 32'(wb_rd0), 32'(e_rd0));
        chk("rnd wb_rd1", 32'(wb_rd1), 32'(e_rd1));
        chk("rnd wb_we0", 32'(wb_we0), 32'(e_we0));
        chk("rnd wb_we1", 32'(wb_we1), 32'(e_we1));
        chk("rnd wb_excp", 32'(wb_excp), 32'(e_excp));
      end
      acc = in_valid && exp_ready && !excp_flush;
      was_done = m_full && !m_wait;
      if (dcache_rready && m_dead > 0) m_dead--;
      if (excp_flush) begin
        if (m_full && m_wait && !resp) m_dead++;
        m_full = 0; m_wait = 0;
      end else begin
        if (resp) begin
          e_d0 = ext_ref(dcache_rdata, e_type, e_sign, e_addr);
          m_wait = 0;
        end
        if (was_done && out_ready) m_full = 0;
        if (acc) begin
          m_full = 1; m_wait = in_is_load && !in_excp;
          e_pc = in_pc0; e_rd0 = in_rd0; e_rd1 = in_rd1;
          e_we0 = in_we0 && !in_excp; e_we1 = in_we1 && !in_excp; e_excp = in_excp;
          e_d0 = in_is_mul ? mul_ref(in_pp_hh, in_pp_hl, in_pp_lh, in_pp_ll, in_pp_comp, in_mul_hi)
                           : in_res0;
          e_d1 = in_res1; e_type = in_ld_type; e_sign = in_ld_sign; e_addr = in_addr_lo;
        end
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
